board_access_arbiter: RTL

- Sits between the two player front-ends and the shared board memory (matrix_mem).
- Grants the single memory port to one player at a time using round-robin arbitration.
- Executes atomic board operations as read-modify-write sequences:
  - SHOT: read the cell, then mark it HIT or MISS.
  - PLACE: read the cell, then write SHIP if the cell is empty.
- Returns a result code and keeps a saturating hit counter per player.

---
 rtl/board_access_arbiter_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/board_access_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/board_access_arbiter_pkg.sv
// Shared encodings for the board access arbiter: cell values, result codes,
// operation codes and the control FSM state type.
package board_access_arbiter_pkg;

  // Board cell contents as stored in matrix_mem
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_HIT   = 2'b10;
  localparam logic [1:0] CELL_MISS  = 2'b11;

  // Result codes; SHOT and PLACE share the 2-bit space
  localparam logic [1:0] RES_MISS     = 2'b00;
  localparam logic [1:0] RES_HIT      = 2'b01;
  localparam logic [1:0] RES_REPEAT   = 2'b10;
  localparam logic [1:0] RES_ERROR    = 2'b11;
  localparam logic [1:0] RES_PLACED   = 2'b00;
  localparam logic [1:0] RES_OCCUPIED = 2'b10;

  // Player operation codes
  localparam logic OP_SHOT  = 1'b0;
  localparam logic OP_PLACE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_ACK
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant. owner remembers the last accepted player
// so that under contention the other player wins next.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req_p1,
  input  logic req_p2,
  input  logic accept,
  output logic gnt_valid,
  output logic gnt_id,
  output logic owner
);

  logic owner_q, owner_d;

  // Grant selection: a lone requester wins, contention goes to the non-owner
  always_comb begin
    gnt_valid = req_p1 | req_p2;
    gnt_id    = (req_p1 && req_p2) ? ~owner_q : req_p2;
    owner_d   = accept ? gnt_id : owner_q;
  end

  // Owner starts at p2 so p1 wins the first contention after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner_q <= 1'b1;
    else     owner_q <= owner_d;
  end

  assign owner = owner_q;

endmodule

// File: rtl/board_access_arbiter.sv
// Shared board memory arbiter: grants one player at a time and runs each
// SHOT/PLACE request as an atomic read-modify-write on matrix_mem.
module board_access_arbiter
  import board_access_arbiter_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int RD_TIMEOUT = 4,
  parameter int HIT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p1_req,
  input  logic             p1_op,
  input  logic [2:0]       p1_x,
  input  logic [2:0]       p1_y,
  input  logic             p2_req,
  input  logic             p2_op,
  input  logic [2:0]       p2_x,
  input  logic [2:0]       p2_y,
  output logic             p1_ack,
  output logic             p2_ack,
  output logic [1:0]       result,
  output logic [HIT_W-1:0] p1_hits,
  output logic [HIT_W-1:0] p2_hits,
  output logic             busy,
  output logic             owner,
  output logic [2:0]       mem_x,
  output logic [2:0]       mem_y,
  output logic             mem_wr_en,
  output logic [1:0]       mem_wdata,
  output logic             mem_valid,
  input  logic [1:0]       mem_rdata,
  input  logic             mem_rdata_valid
);

  localparam int TMO_W = $clog2(RD_TIMEOUT) + 1;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [2:0]       x_q, x_d, y_q, y_d;
  logic             who_q, who_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       pend_res_q, pend_res_d;
  logic [1:0]       result_q, result_d;
  logic             busy_q, busy_d;
  logic             p1_ack_q, p1_ack_d, p2_ack_q, p2_ack_d;
  logic [HIT_W-1:0] p1_hits_q, p1_hits_d, p2_hits_q, p2_hits_d;
  logic [2:0]       mem_x_q, mem_x_d, mem_y_q, mem_y_d;
  logic             mem_valid_q, mem_valid_d, mem_wr_en_q, mem_wr_en_d;
  logic [1:0]       mem_wdata_q, mem_wdata_d;
  logic             gnt_valid, gnt_id, accept, mem_active;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_p1    (p1_req),
    .req_p2    (p2_req),
    .accept    (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .owner     (owner)
  );

  // Next-state and next-output logic; outputs are registered alongside state
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    who_d       = who_q;
    tmo_d       = tmo_q;
    pend_res_d  = pend_res_q;
    result_d    = result_q;
    busy_d      = busy_q;
    p1_hits_d   = p1_hits_q;
    p2_hits_d   = p2_hits_q;
    mem_wdata_d = 2'b00;
    accept      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          accept = 1'b1;
          who_d  = gnt_id;
          op_d   = gnt_id ? p2_op : p1_op;
          x_d    = gnt_id ? p2_x  : p1_x;
          y_d    = gnt_id ? p2_y  : p1_y;
          busy_d = 1'b1;
          if (int'(x_d) >= WIDTH || int'(y_d) >= WIDTH) begin
            result_d = RES_ERROR;
            state_d  = ST_ACK;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rdata_valid) begin
          if (op_q == OP_SHOT) begin
            unique case (mem_rdata)
              CELL_SHIP: begin
                mem_wdata_d = CELL_HIT;
                pend_res_d  = RES_HIT;
                state_d     = ST_WR;
              end
              CELL_EMPTY: begin
                mem_wdata_d = CELL_MISS;
                pend_res_d  = RES_MISS;
                state_d     = ST_WR;
              end
              CELL_HIT, CELL_MISS: begin
                result_d = RES_REPEAT;
                state_d  = ST_ACK;
              end
            endcase
          end else if (mem_rdata == CELL_EMPTY) begin
            mem_wdata_d = CELL_SHIP;
            pend_res_d  = RES_PLACED;
            state_d     = ST_WR;
          end else begin
            result_d = RES_OCCUPIED;
            state_d  = ST_ACK;
          end
        end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
          result_d = RES_ERROR;
          state_d  = ST_ACK;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WR: begin
        result_d = pend_res_q;
        state_d  = ST_ACK;
      end
      ST_ACK: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (op_q == OP_SHOT && result_q == RES_HIT) begin
          if (!who_q && p1_hits_q != {HIT_W{1'b1}}) p1_hits_d = p1_hits_q + HIT_W'(1);
          if (who_q  && p2_hits_q != {HIT_W{1'b1}}) p2_hits_d = p2_hits_q + HIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ack and memory strobes follow the state being entered so they are flops
    p1_ack_d    = (state_d == ST_ACK) && !who_d;
    p2_ack_d    = (state_d == ST_ACK) &&  who_d;
    mem_active  = (state_d == ST_RD) || (state_d == ST_WAIT) || (state_d == ST_WR);
    mem_valid_d = mem_active;
    mem_wr_en_d = (state_d == ST_WR);
    mem_x_d     = mem_active ? x_d : 3'd0;
    mem_y_d     = mem_active ? y_d : 3'd0;
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      who_q       <= 1'b0;
      tmo_q       <= '0;
      pend_res_q  <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      p1_ack_q    <= 1'b0;
      p2_ack_q    <= 1'b0;
      p1_hits_q   <= '0;
      p2_hits_q   <= '0;
      mem_x_q     <= '0;
      mem_y_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      who_q       <= who_d;
      tmo_q       <= tmo_d;
      pend_res_q  <= pend_res_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      p1_ack_q    <= p1_ack_d;
      p2_ack_q    <= p2_ack_d;
      p1_hits_q   <= p1_hits_d;
      p2_hits_q   <= p2_hits_d;
      mem_x_q     <= mem_x_d;
      mem_y_q     <= mem_y_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign p1_ack    = p1_ack_q;
  assign p2_ack    = p2_ack_q;
  assign result    = result_q;
  assign p1_hits   = p1_hits_q;
  assign p2_hits   = p2_hits_q;
  assign busy      = busy_q;
  assign mem_x     = mem_x_q;
  assign mem_y     = mem_y_q;
  assign mem_valid = mem_valid_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_wdata = mem_wdata_q;

endmodule
